aes_kat_sequencer: RTL and testbench

Synthesisable known-answer-test (KAT) sequencer for the AES-128 encryption core `aes_cipher_top`. It reads a parametrised number of key/plaintext/expected-ciphertext vectors from a synchronous vector ROM and drives each vector through the cipher. It compares every result and accumulates pass/fail statistics, with timeout detection and optional stop-on-first-fail. It sits beside the cipher as an on-chip built-in self-test and replaces bench-only vector checking.

---
 rtl/aes_kat_pkg.sv | 22 ++
 rtl/aes_kat_vector_rom.sv | 56 +++++
 rtl/aes_kat_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_aes_kat_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_kat_pkg.sv
// Shared types and constants for the AES-128 known-answer-test sequencer.
package aes_kat_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_DONE
    } kat_state_t;

    typedef struct packed {
        logic [AES_BLK_W-1:0] key;
        logic [AES_BLK_W-1:0] pt;
        logic [AES_BLK_W-1:0] ct;
    } kat_vec_t;

endpackage

// File: rtl/aes_kat_vector_rom.sv
// Default AES-128 KAT vector table with a one-cycle synchronous read.
module aes_kat_vector_rom
    import aes_kat_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                 clk,
    input  logic [IDX_W-1:0]     addr,
    output logic [AES_BLK_W-1:0] key,
    output logic [AES_BLK_W-1:0] pt,
    output logic [AES_BLK_W-1:0] ct
);

    kat_vec_t   rd_d;
    kat_vec_t   rd_q;
    logic [1:0] sel;

    // Tables larger than four entries repeat the base set.
    assign sel = 2'(32'(addr));

    always_comb begin
        rd_d = '0;
        case (sel)
            2'd0: begin
                rd_d.key = 128'h000102030405060708090a0b0c0d0e0f;
                rd_d.pt  = 128'h00112233445566778899aabbccddeeff;
                rd_d.ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            end
            2'd1: begin
                rd_d.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
                rd_d.pt  = 128'h6bc1bee22e409f96e93d7e117393172a;
                rd_d.ct  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
            end
            2'd2: begin
                rd_d.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
                rd_d.pt  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
                rd_d.ct  = 128'hf5d3d58503b9699de785895a96fdbaaf;
            end
            default: begin
                rd_d.key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
                rd_d.pt  = 128'h3243f6a8885a308d313198a2e0370734;
                rd_d.ct  = 128'h3925841d02dc09fbdc118597196a0b32;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rd_q <= rd_d;
    end

    assign key = rd_q.key;
    assign pt  = rd_q.pt;
    assign ct  = rd_q.ct;

endmodule

// File: rtl/aes_kat_sequencer.sv
// Built-in self-test sequencer: runs ROM vectors through an AES-128 core and
// accumulates pass/fail statistics with timeout and stop-on-fail support.
module aes_kat_sequencer
    import aes_kat_pkg::*;
#(
    parameter int NUM_VECTORS    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int GAP_CYCLES     = 4,
    parameter int IDX_W          = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    parameter int CNT_W          = $clog2(NUM_VECTORS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop_on_fail,
    output logic [IDX_W-1:0]     vec_addr,
    input  logic [AES_BLK_W-1:0] vec_key,
    input  logic [AES_BLK_W-1:0] vec_pt,
    input  logic [AES_BLK_W-1:0] vec_ct,
    output logic                 dut_ld,
    output logic [AES_BLK_W-1:0] dut_key,
    output logic [AES_BLK_W-1:0] dut_text_in,
    input  logic [AES_BLK_W-1:0] dut_text_out,
    input  logic                 dut_done,
    output logic                 busy,
    output logic                 finished,
    output logic                 all_pass,
    output logic [CNT_W-1:0]     pass_count,
    output logic [CNT_W-1:0]     fail_count,
    output logic                 any_fail,
    output logic [IDX_W-1:0]     first_fail_idx,
    output logic                 timeout_seen
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    kat_state_t           state;
    kat_state_t           state_d;
    logic [AES_BLK_W-1:0] exp_r;
    logic [AES_BLK_W-1:0] res_r;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 tmo_r;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 sof_r;

    logic done_ok;
    logic tmo_hit;
    logic vec_pass;
    logic last_vec;
    logic ld_d;
    logic busy_d;
    logic fin_d;

    // dut_ld is high exactly in the first WAIT_DONE cycle, so it doubles as
    // the "ignore dut_done this cycle" qualifier.
    assign done_ok  = (state == ST_WAIT_DONE) && !dut_ld && dut_done;
    assign tmo_hit  = (state == ST_WAIT_DONE) && !done_ok && (tmo_cnt == TMO_LAST);
    assign vec_pass = !tmo_r && (res_r == exp_r);
    assign last_vec = (vec_addr == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH:     state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done_ok || tmo_hit) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (last_vec || (!vec_pass && sof_r)) state_d = ST_DONE;
                else if (GAP_CYCLES == 0)             state_d = ST_FETCH;
                else                                  state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = ST_FETCH;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_d   = (state == ST_LOAD);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        fin_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_addr       <= '0;
            dut_ld         <= 1'b0;
            dut_key        <= '0;
            dut_text_in    <= '0;
            busy           <= 1'b0;
            finished       <= 1'b0;
            all_pass       <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            any_fail       <= 1'b0;
            first_fail_idx <= '0;
            timeout_seen   <= 1'b0;
            exp_r          <= '0;
            res_r          <= '0;
            tmo_cnt        <= '0;
            tmo_r          <= 1'b0;
            gap_cnt        <= '0;
            sof_r          <= 1'b0;
        end else begin
            dut_ld   <= ld_d;
            busy     <= busy_d;
            finished <= fin_d;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec_addr       <= '0;
                        all_pass       <= 1'b0;
                        pass_count     <= '0;
                        fail_count     <= '0;
                        any_fail       <= 1'b0;
                        first_fail_idx <= '0;
                        timeout_seen   <= 1'b0;
                        sof_r          <= stop_on_fail;
                    end
                end
                ST_LOAD: begin
                    dut_key     <= vec_key;
                    dut_text_in <= vec_pt;
                    exp_r       <= vec_ct;
                    tmo_cnt     <= '0;
                    tmo_r       <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (done_ok) begin
                        res_r <= dut_text_out;
                    end else if (tmo_hit) begin
                        tmo_r        <= 1'b1;
                        timeout_seen <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (vec_pass) begin
                        pass_count <= pass_count + CNT_W'(1);
                    end else begin
                        fail_count <= fail_count + CNT_W'(1);
                        if (!any_fail) begin
                            any_fail       <= 1'b1;
                            first_fail_idx <= vec_addr;
                        end
                    end
                    if (state_d == ST_DONE) begin
                        all_pass <= vec_pass && (fail_count == '0) && last_vec;
                    end else begin
                        vec_addr <= vec_addr + IDX_W'(1);
                        gap_cnt  <= '0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Directed bench for aes_kat_sequencer with table-driven AES cipher stubs.
module tb_aes_kat_sequencer;
    import aes_kat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] tv_key [4];
    logic [127:0] tv_pt  [4];
    logic [127:0] tv_ct  [4];
    logic [127:0] rom_ct [4];

    // ---------------- DUT A: bench ROM, GAP=2, TIMEOUT=16 ----------------
    logic         a_start = 1'b0;
    logic         a_sof   = 1'b0;
    logic [1:0]   a_addr;
    logic [127:0] a_vkey, a_vpt, a_vct;
    logic         a_ld;
    logic [127:0] a_key, a_tin;
    logic [127:0] a_tout = '0;
    logic         a_done = 1'b0;
    logic         a_busy, a_fin, a_allp, a_anyf, a_tmo;
    logic [2:0]   a_pc, a_fc;
    logic [1:0]   a_ffi;

    aes_kat_sequencer #(
        .NUM_VECTORS(4), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .stop_on_fail(a_sof),
        .vec_addr(a_addr), .vec_key(a_vkey), .vec_pt(a_vpt), .vec_ct(a_vct),
        .dut_ld(a_ld), .dut_key(a_key), .dut_text_in(a_tin),
        .dut_text_out(a_tout), .dut_done(a_done),
        .busy(a_busy), .finished(a_fin), .all_pass(a_allp),
        .pass_count(a_pc), .fail_count(a_fc), .any_fail(a_anyf),
        .first_fail_idx(a_ffi), .timeout_seen(a_tmo)
    );

    // ---------------- DUT B: default ROM, GAP=0 ----------------
    logic         b_start = 1'b0;
    logic [1:0]   b_addr;
    logic [127:0] b_vkey, b_vpt, b_vct;
    logic         b_ld;
    logic [127:0] b_key, b_tin;
    logic [127:0] b_tout = '0;
    logic         b_done = 1'b0;
    logic         b_busy, b_fin, b_allp, b_anyf, b_tmo;
    logic [2:0]   b_pc, b_fc;
    logic [1:0]   b_ffi;

    aes_kat_vector_rom #(.NUM_VECTORS(4)) rom_b (
        .clk(clk), .addr(b_addr), .key(b_vkey), .pt(b_vpt), .ct(b_vct)
    );

    aes_kat_sequencer #(
        .NUM_VECTORS(4), .TIMEOUT_CYCLES(64), .GAP_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .stop_on_fail(1'b0),
        .vec_addr(b_addr), .vec_key(b_vkey), .vec_pt(b_vpt), .vec_ct(b_vct),
        .dut_ld(b_ld), .dut_key(b_key), .dut_text_in(b_tin),
        .dut_text_out(b_tout), .dut_done(b_done),
        .busy(b_busy), .finished(b_fin), .all_pass(b_allp),
        .pass_count(b_pc), .fail_count(b_fc), .any_fail(b_anyf),
        .first_fail_idx(b_ffi), .timeout_seen(b_tmo)
    );

    // Stub cipher: returns the true ciphertext for a known key/pt pair.
    function automatic logic [127:0] true_ct(input logic [127:0] k, input logic [127:0] p);
        for (int i = 0; i < 4; i++)
            if (tv_key[i] == k && tv_pt[i] == p) return tv_ct[i];
        return '0;
    endfunction

    // Bench ROM for DUT A (expected value is corruptible).
    always @(posedge clk) begin
        a_vkey <= tv_key[a_addr];
        a_vpt  <= tv_pt[a_addr];
        a_vct  <= rom_ct[a_addr];
    end

    // Stubs: done arrives 4 cycles after the dut_ld cycle.
    int a_cnt = 0;
    int b_cnt = 0;
    bit a_never = 1'b0;
    int a_ldn = 0;
    int b_ldn = 0;

    always @(posedge clk) begin
        a_done <= 1'b0;
        if (a_ld) a_ldn <= a_ldn + 1;
        if (rst) a_cnt <= 0;
        else if (a_ld) a_cnt <= 3;
        else if (a_cnt > 0) begin
            a_cnt <= a_cnt - 1;
            if (a_cnt == 1 && !a_never) begin
                a_done <= 1'b1;
                a_tout <= true_ct(a_key, a_tin);
            end
        end
    end

    always @(posedge clk) begin
        b_done <= 1'b0;
        if (b_ld) b_ldn <= b_ldn + 1;
        if (rst) b_cnt <= 0;
        else if (b_ld) b_cnt <= 3;
        else if (b_cnt > 0) begin
            b_cnt <= b_cnt - 1;
            if (b_cnt == 1) begin
                b_done <= 1'b1;
                b_tout <= true_ct(b_key, b_tin);
            end
        end
    end

    // Start DUT A and wait for finished; optionally re-pulse start at a cycle.
    task automatic run_a(input bit sof, input int restart_at, output int cycles);
        @(posedge clk); #1 a_sof = sof; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cycles = 1;
        while (!a_fin && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
            a_start = (cycles == restart_at);
        end
        a_start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({a_busy, a_fin, a_allp, a_anyf, a_tmo, a_ld} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 000000", {a_busy, a_fin, a_allp, a_anyf, a_tmo, a_ld}); end
        checks++; if ({a_pc, a_fc, a_ffi, a_addr} !== 10'b0) begin
            failures++; $display("FAIL reset_counts: got %h want 0", {a_pc, a_fc, a_ffi, a_addr}); end
        checks++; if ({a_key, a_tin} !== 256'b0) begin
            failures++; $display("FAIL reset_operands: got %h want 0", {a_key, a_tin}); end
        checks++; if ({b_busy, b_fin, b_ld, b_pc, b_fc} !== 9'b0) begin
            failures++; $display("FAIL reset_b: got %h want 0", {b_busy, b_fin, b_ld, b_pc, b_fc}); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        int ld0;
        ld0 = a_ldn;
        @(posedge clk); #1 a_sof = 1'b0; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 1;
        checks++; if (a_busy !== 1'b1 || a_addr !== 2'd0 || a_ld !== 1'b0) begin
            failures++; $display("FAIL fetch_cycle: got busy=%b addr=%0d ld=%b want 1 0 0", a_busy, a_addr, a_ld); end
        while (!a_fin && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) begin
                checks++; if (a_ld !== 1'b0) begin failures++; $display("FAIL ld_in_load: got %b want 0", a_ld); end
            end
            if (cyc == 3) begin
                checks++; if (a_ld !== 1'b1 || a_key !== tv_key[0] || a_tin !== tv_pt[0]) begin
                    failures++; $display("FAIL ld_vec0: got ld=%b key=%h pt=%h want 1 %h %h", a_ld, a_key, a_tin, tv_key[0], tv_pt[0]); end
            end
            if (cyc == 4) begin
                checks++; if (a_ld !== 1'b0) begin failures++; $display("FAIL ld_one_cycle: got %b want 0", a_ld); end
            end
            if (cyc == 8) begin
                checks++; if (a_pc !== 3'd0) begin failures++; $display("FAIL pc_in_check: got %0d want 0", a_pc); end
            end
            if (cyc == 9) begin
                checks++; if (a_pc !== 3'd1 || a_addr !== 2'd1 || a_key !== tv_key[0]) begin
                    failures++; $display("FAIL fips_vec0: got pc=%0d addr=%0d key=%h want 1 1 %h", a_pc, a_addr, a_key, tv_key[0]); end
            end
            if (cyc == 13) begin
                checks++; if (a_ld !== 1'b1 || a_tin !== tv_pt[1]) begin
                    failures++; $display("FAIL ld_vec1: got ld=%b pt=%h want 1 %h", a_ld, a_tin, tv_pt[1]); end
            end
        end
        checks++; if (cyc !== 39) begin failures++; $display("FAIL run_len_gap2: got %0d want 39", cyc); end
        checks++; if (a_pc !== 3'd4 || a_fc !== 3'd0 || a_allp !== 1'b1 || a_busy !== 1'b0 || a_anyf !== 1'b0) begin
            failures++; $display("FAIL all_pass_a: got pc=%0d fc=%0d allp=%b busy=%b anyf=%b want 4 0 1 0 0", a_pc, a_fc, a_allp, a_busy, a_anyf); end
        checks++; if (a_ldn - ld0 !== 4) begin failures++; $display("FAIL ld_count_a: got %0d want 4", a_ldn - ld0); end
    endtask

    task automatic test_no_gap;
        int cyc;
        int ld0;
        ld0 = b_ldn;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cyc = 1;
        while (!b_fin && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 9) begin
                checks++; if (b_addr !== 2'd1 || b_pc !== 3'd1) begin
                    failures++; $display("FAIL nogap_fetch1: got addr=%0d pc=%0d want 1 1", b_addr, b_pc); end
            end
        end
        checks++; if (cyc !== 33) begin failures++; $display("FAIL run_len_gap0: got %0d want 33", cyc); end
        checks++; if (b_pc !== 3'd4 || b_fc !== 3'd0 || b_allp !== 1'b1 || b_tmo !== 1'b0) begin
            failures++; $display("FAIL nogap_result: got pc=%0d fc=%0d allp=%b tmo=%b want 4 0 1 0", b_pc, b_fc, b_allp, b_tmo); end
        checks++; if (b_ldn - ld0 !== 4) begin failures++; $display("FAIL ld_count_b: got %0d want 4", b_ldn - ld0); end
    endtask

    task automatic test_corrupt;
        int cyc;
        rom_ct[2] = tv_ct[2] ^ 128'd1;
        run_a(1'b0, 0, cyc);
        checks++; if (cyc !== 39) begin failures++; $display("FAIL corrupt_len: got %0d want 39", cyc); end
        checks++; if (a_pc !== 3'd3 || a_fc !== 3'd1 || a_ffi !== 2'd2 || a_anyf !== 1'b1 || a_allp !== 1'b0 || a_tmo !== 1'b0) begin
            failures++; $display("FAIL corrupt_result: got pc=%0d fc=%0d ffi=%0d anyf=%b allp=%b tmo=%b want 3 1 2 1 0 0", a_pc, a_fc, a_ffi, a_anyf, a_allp, a_tmo); end
    endtask

    task automatic test_stop_on_fail;
        int cyc;
        run_a(1'b1, 0, cyc);
        checks++; if (cyc !== 29) begin failures++; $display("FAIL sof_len: got %0d want 29", cyc); end
        checks++; if (a_pc !== 3'd2 || a_fc !== 3'd1 || a_allp !== 1'b0 || a_ffi !== 2'd2 || a_addr !== 2'd2 || a_fin !== 1'b1) begin
            failures++; $display("FAIL sof_result: got pc=%0d fc=%0d allp=%b ffi=%0d addr=%0d fin=%b want 2 1 0 2 2 1", a_pc, a_fc, a_allp, a_ffi, a_addr, a_fin); end
        rom_ct[2] = tv_ct[2];
    endtask

    task automatic test_timeout;
        int cyc;
        a_never = 1'b1;
        @(posedge clk); #1 a_sof = 1'b1; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 1;
        while (!a_fin && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 19) begin
                checks++; if (a_fc !== 3'd0 || a_tmo !== 1'b1) begin
                    failures++; $display("FAIL tmo_check_cycle: got fc=%0d tmo=%b want 0 1", a_fc, a_tmo); end
            end
        end
        checks++; if (cyc !== 20) begin failures++; $display("FAIL tmo_len: got %0d want 20", cyc); end
        checks++; if (a_fc !== 3'd1 || a_pc !== 3'd0 || a_tmo !== 1'b1 || a_anyf !== 1'b1 || a_ffi !== 2'd0 || a_allp !== 1'b0) begin
            failures++; $display("FAIL tmo_result: got fc=%0d pc=%0d tmo=%b anyf=%b ffi=%0d allp=%b want 1 0 1 1 0 0", a_fc, a_pc, a_tmo, a_anyf, a_ffi, a_allp); end
        a_never = 1'b0;
    endtask

    task automatic test_reset_restart;
        int cyc;
        int ld0;
        @(posedge clk); #1 a_sof = 1'b0; a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        cyc = 1;
        while (cyc < 14) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (a_busy !== 1'b1 || a_pc !== 3'd1 || a_addr !== 2'd1 || a_tmo !== 1'b0) begin
            failures++; $display("FAIL pre_rst: got busy=%b pc=%0d addr=%0d tmo=%b want 1 1 1 0", a_busy, a_pc, a_addr, a_tmo); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({a_busy, a_fin, a_allp, a_anyf, a_tmo, a_ld, a_pc, a_fc, a_ffi, a_addr} !== 16'b0) begin
            failures++; $display("FAIL mid_rst_state: got %h want 0", {a_busy, a_fin, a_allp, a_anyf, a_tmo, a_ld, a_pc, a_fc, a_ffi, a_addr}); end
        checks++; if ({a_key, a_tin} !== 256'b0) begin
            failures++; $display("FAIL mid_rst_operands: got %h want 0", {a_key, a_tin}); end
        rst = 1'b0;
        ld0 = a_ldn;
        run_a(1'b0, 5, cyc);
        checks++; if (cyc !== 39) begin failures++; $display("FAIL restart_len: got %0d want 39", cyc); end
        checks++; if (a_pc !== 3'd4 || a_fc !== 3'd0 || a_allp !== 1'b1 || a_tmo !== 1'b0) begin
            failures++; $display("FAIL restart_result: got pc=%0d fc=%0d allp=%b tmo=%b want 4 0 1 0", a_pc, a_fc, a_allp, a_tmo); end
        checks++; if (a_ldn - ld0 !== 4) begin failures++; $display("FAIL restart_ld_count: got %0d want 4", a_ldn - ld0); end
    endtask

    initial begin
        tv_key[0] = 128'h000102030405060708090a0b0c0d0e0f;
        tv_pt[0]  = 128'h00112233445566778899aabbccddeeff;
        tv_ct[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        tv_key[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tv_pt[1]  = 128'h6bc1bee22e409f96e93d7e117393172a;
        tv_ct[1]  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        tv_key[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tv_pt[2]  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        tv_ct[2]  = 128'hf5d3d58503b9699de785895a96fdbaaf;
        tv_key[3] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tv_pt[3]  = 128'h3243f6a8885a308d313198a2e0370734;
        tv_ct[3]  = 128'h3925841d02dc09fbdc118597196a0b32;
        for (int i = 0; i < 4; i++) rom_ct[i] = tv_ct[i];

        test_reset();
        test_basic();
        test_no_gap();
        test_corrupt();
        test_stop_on_fail();
        test_timeout();
        test_reset_restart();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
